// File: rtl/c499_key_sequencer.sv
// Key loader and request sequencer for an external key-locked c499 SEC datapath.
// Optional C499_KEY_ZEROIZE_EN adds zeroize_i for an immediate key/state wipe.
module c499_key_sequencer #(
  parameter int KEY_W  = 32,
  parameter int DATA_W = 32,
  parameter int CHK_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_start_i,
  input  logic                    key_valid_i,
  input  logic                    key_bit_i,
  output logic                    key_busy_o,
  output logic                    key_loaded_o,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [DATA_W-1:0]       req_data_i,
  input  logic [CHK_W-1:0]        req_chk_i,
  input  logic                    req_en_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic [DATA_W+CHK_W:0]   ecc_g_o,
  output logic [KEY_W-1:0]        ecc_k_o,
`ifdef C499_KEY_ZEROIZE_EN
  input  logic                    zeroize_i,
`endif
  input  logic [DATA_W-1:0]       ecc_out_i
);

  localparam int CW = $clog2(KEY_W);
  localparam int GW = DATA_W + CHK_W + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, ARMED, WAIT, RESP
  } state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         settle_q, settle_d;
  logic               pend_q, pend_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [GW-1:0]      g_q, g_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               loaded_q, loaded_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  // Next-state and next-register values; outputs derive from registered state.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    pend_d   = pend_q;
    key_d    = key_q;
    g_d      = g_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    loaded_d = loaded_q;
    unique case (state_q)
      IDLE: begin
        if (key_start_i) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      LOAD: begin
        if (key_start_i) begin
          cnt_d    = '0;
          shadow_d = '0;
        end else if (key_valid_i) begin
          shadow_d[cnt_q] = key_bit_i;
          if (cnt_q == CW'(KEY_W-1)) begin
            key_d    = shadow_d;
            loaded_d = 1'b1;
            cnt_d    = '0;
            state_d  = ARMED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ARMED: begin
        if (key_start_i) begin
          state_d  = LOAD;
          cnt_d    = '0;
          shadow_d = '0;
          loaded_d = 1'b0;
        end else if (req_valid_i && ready_q) begin
          g_d      = {req_en_i, req_chk_i, req_data_i};
          settle_d = 4'(SETTLE-1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (key_start_i) pend_d = 1'b1;
        if (settle_q == 4'd0) begin
          rdata_d  = ecc_out_i;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      RESP: begin
        if (key_start_i) pend_d = 1'b1;
        if (rsp_ready_i) begin
          rvalid_d = 1'b0;
          if (pend_q || key_start_i) begin
            pend_d   = 1'b0;
            state_d  = LOAD;
            cnt_d    = '0;
            shadow_d = '0;
            loaded_d = 1'b0;
          end else begin
            state_d = ARMED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef C499_KEY_ZEROIZE_EN
    if (zeroize_i) begin
      state_d  = IDLE;
      shadow_d = '0;
      cnt_d    = '0;
      settle_d = '0;
      pend_d   = 1'b0;
      key_d    = '0;
      g_d      = '0;
      rdata_d  = '0;
      rvalid_d = 1'b0;
      loaded_d = 1'b0;
    end
`endif
    busy_d  = (state_d == LOAD);
    ready_d = (state_d == ARMED);
  end

  // State and output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      pend_q   <= 1'b0;
      key_q    <= '0;
      g_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      loaded_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      pend_q   <= pend_d;
      key_q    <= key_d;
      g_q      <= g_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      loaded_q <= loaded_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign key_busy_o   = busy_q;
  assign key_loaded_o = loaded_q;
  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rvalid_q;
  assign rsp_data_o   = rdata_q;
  assign ecc_g_o      = g_q;
  assign ecc_k_o      = key_q;

endmodule

// File: tb/tb_c499_key_sequencer.sv
// Directed bench for c499_key_sequencer; c499 modelled as data ^ 1.
// Covers C499_KEY_ZEROIZE_EN when defined.
module tb_c499_key_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_start_i = 1'b0;
  logic        key_valid_i = 1'b0;
  logic        key_bit_i = 1'b0;
  logic        key_busy_o;
  logic        key_loaded_o;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_data_i = '0;
  logic [7:0]  req_chk_i = '0;
  logic        req_en_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [40:0] ecc_g_o;
  logic [31:0] ecc_k_o;
  logic [31:0] ecc_out_i;
`ifdef C499_KEY_ZEROIZE_EN
  logic        zeroize_i = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ecc_out_i = ecc_g_o[31:0] ^ 32'h0000_0001;

  c499_key_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_start_i  (key_start_i),
    .key_valid_i  (key_valid_i),
    .key_bit_i    (key_bit_i),
    .key_busy_o   (key_busy_o),
    .key_loaded_o (key_loaded_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data_i   (req_data_i),
    .req_chk_i    (req_chk_i),
    .req_en_i     (req_en_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .ecc_g_o      (ecc_g_o),
    .ecc_k_o      (ecc_k_o),
`ifdef C499_KEY_ZEROIZE_EN
    .zeroize_i    (zeroize_i),
`endif
    .ecc_out_i    (ecc_out_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    key_start_i = 1'b1;
    tick();
    key_start_i = 1'b0;
  endtask

  task automatic load_bits(input logic [31:0] k, input int lo,
                           input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      if (gap && (i % 3 == 2)) begin
        key_valid_i = 1'b0;
        tick();
      end
      key_valid_i = 1'b1;
      key_bit_i   = k[i];
      tick();
    end
    key_valid_i = 1'b0;
  endtask

  task automatic accept(input logic [31:0] d, input logic [7:0] c,
                        input logic e);
    req_valid_i = 1'b1;
    req_data_i  = d;
    req_chk_i   = c;
    req_en_i    = e;
    tick();
    req_valid_i = 1'b0;
  endtask

  initial begin
    // Reset and idle with a request pending.
    tick();
    tick();
    rst_n = 1'b1;
    req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_ready", req_ready_o, 0);
    end
    req_valid_i = 1'b0;
    check("rst_k", ecc_k_o, 0);
    check("rst_g", ecc_g_o, 0);
    check("rst_rdata", rsp_data_o, 0);
    check("rst_rvalid", rsp_valid_o, 0);
    check("rst_busy", key_busy_o, 0);
    check("rst_loaded", key_loaded_o, 0);

    // Key load with gaps.
    pulse_start();
    check("load_busy", key_busy_o, 1);
    check("load_loaded", key_loaded_o, 0);
    load_bits(32'hA5A5_0F0F, 0, 30, 1'b1);
    check("load31_loaded", key_loaded_o, 0);
    check("load31_k", ecc_k_o, 0);
    load_bits(32'hA5A5_0F0F, 31, 31, 1'b1);
    check("load32_loaded", key_loaded_o, 1);
    check("load32_k", ecc_k_o, 64'hA5A5_0F0F);
    check("load32_busy", key_busy_o, 0);
    check("armed_ready", req_ready_o, 1);

    // Transaction with backpressure.
    accept(32'h1234_5678, 8'h3C, 1'b1);
    check("acc_g", ecc_g_o, 64'h13C_1234_5678);
    check("acc_ready", req_ready_o, 0);
    check("acc_rvalid", rsp_valid_o, 0);
    tick();
    check("lat1_rvalid", rsp_valid_o, 0);
    tick();
    check("lat2_rvalid", rsp_valid_o, 1);
    check("lat2_rdata", rsp_data_o, 64'h1234_5679);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rvalid", rsp_valid_o, 1);
      check("bp_rdata", rsp_data_o, 64'h1234_5679);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("hs_rvalid", rsp_valid_o, 0);
    check("hs_ready", req_ready_o, 1);
    check("hs_rdata_kept", rsp_data_o, 64'h1234_5679);

    // Restart request during WAIT.
    accept(32'hCAFE_F00D, 8'h11, 1'b0);
    check("acc2_g", ecc_g_o, 64'h011_CAFE_F00D);
    pulse_start();
    check("wait_rvalid", rsp_valid_o, 0);
    tick();
    check("wr_rvalid", rsp_valid_o, 1);
    check("wr_rdata", rsp_data_o, 64'hCAFE_F00C);
    check("wr_k_old", ecc_k_o, 64'hA5A5_0F0F);
    check("wr_loaded", key_loaded_o, 1);
    check("wr_busy", key_busy_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("pr_busy", key_busy_o, 1);
    check("pr_loaded", key_loaded_o, 0);
    check("pr_ready", req_ready_o, 0);
    check("pr_k_held", ecc_k_o, 64'hA5A5_0F0F);

    // Partial load then restart.
    load_bits(32'hFFFF_FFFF, 0, 16, 1'b0);
    check("part_k_held", ecc_k_o, 64'hA5A5_0F0F);
    key_start_i = 1'b1;
    key_valid_i = 1'b1;
    key_bit_i   = 1'b1;
    tick();
    key_start_i = 1'b0;
    key_valid_i = 1'b0;
    load_bits(32'h0000_0001, 0, 30, 1'b0);
    check("rl31_loaded", key_loaded_o, 0);
    load_bits(32'h0000_0001, 31, 31, 1'b0);
    check("rl_loaded", key_loaded_o, 1);
    check("rl_k", ecc_k_o, 64'h1);

    // Reset mid-load.
    pulse_start();
    load_bits(32'hFFFF_FFFF, 0, 19, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_k", ecc_k_o, 0);
    check("mr_loaded", key_loaded_o, 0);
    check("mr_busy", key_busy_o, 0);
    tick();
    rst_n = 1'b1;
    req_valid_i = 1'b1;
    tick();
    check("mr_idle_ready", req_ready_o, 0);
    tick();
    check("mr_idle_ready2", req_ready_o, 0);
    req_valid_i = 1'b0;

`ifdef C499_KEY_ZEROIZE_EN
    // Zeroize from RESP.
    pulse_start();
    load_bits(32'h5555_AAAA, 0, 31, 1'b0);
    check("z_loaded_pre", key_loaded_o, 1);
    accept(32'h0F0F_0F0F, 8'h22, 1'b1);
    tick();
    tick();
    check("z_rvalid_pre", rsp_valid_o, 1);
    zeroize_i = 1'b1;
    tick();
    zeroize_i = 1'b0;
    check("z_rvalid", rsp_valid_o, 0);
    check("z_k", ecc_k_o, 0);
    check("z_loaded", key_loaded_o, 0);
    check("z_g", ecc_g_o, 0);
    check("z_rdata", rsp_data_o, 0);
    req_valid_i = 1'b1;
    tick();
    check("z_idle_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
